// File: rtl/gray_code_counter_if.sv
// Purpose: control and status bundle of the Gray code counter.
// Signals:
//   en        count enable, one step per clock while high
//   up_dn     1 = count up, 0 = count down
//   load      synchronous load of load_bin, wins over en
//   load_bin  binary value to load
//   bin       registered binary count
//   gray      registered Gray code of bin
//   wrap      one-cycle pulse after a step that wrapped around
// Modports: master drives the controls, slave (the counter) drives the status.
interface gray_code_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_bin,
    input  bin, gray, wrap
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output bin, gray, wrap
  );
endinterface

// File: rtl/gray_code_counter.sv
// Purpose: up/down binary counter with a registered Gray code output, so the
// Gray value can be handed to a clock-domain crossing without glitches.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   gray_code_counter_if.slave: en, up_dn, load, load_bin in;
//         bin, gray, wrap out (all registered)
// Parameters:
//   WIDTH     count width in bits (>= 2)
//   INIT_BIN  binary value taken on reset
module gray_code_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_BIN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_code_counter_if.slave    bus
);

  localparam int unsigned W = WIDTH;
  localparam logic [W-1:0] INIT_B   = W'(INIT_BIN);
  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ZERO     = '0;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         wrap_q;
  logic [W-1:0] bin_nxt;
  logic         wrap_nxt;

  // Next count: load wins over en; wrap flags only a stepping roll-over.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      bin_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        bin_nxt  = bin_q + W'(1);
        wrap_nxt = (bin_q == ALL_ONES);
      end else begin
        bin_nxt  = bin_q - W'(1);
        wrap_nxt = (bin_q == ZERO);
      end
    end
  end

  // Gray is encoded from the next binary value so both register together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= INIT_B;
      gray_q <= to_gray(INIT_B);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= to_gray(bin_nxt);
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Purpose: self-checking bench for gray_code_counter (WIDTH=4): directed
// sweeps, a stimulus table, an asynchronous reset sequence and random traffic
// compared against an arithmetic reference model.
module tb_gray_code_counter;

  localparam int unsigned WIDTH = 4;
  localparam int MOD = 16;

  typedef struct {
    bit         load;
    logic [3:0] load_bin;
    bit         en;
    bit         up_dn;
    logic [3:0] exp_bin;
    logic [3:0] exp_gray;
    bit         exp_wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // Reference state: plain integer count modulo 2^WIDTH
  int m_bin  = 0;
  int m_wrap = 0;

  logic [3:0] up_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101,
                              4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                              4'b1000, 4'b0000};

  vec_t vecs[$];

  gray_code_counter_if #(.WIDTH(WIDTH)) bus ();

  gray_code_counter #(.WIDTH(WIDTH), .INIT_BIN(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic int gray_to_bin(input int g);
    int b;
    int acc;
    b   = 0;
    acc = 0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc = acc ^ ((g >> i) & 1);
      b   = b | (acc << i);
    end
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit l, input int lb, input bit e, input bit u);
    bus.load     = l;
    bus.load_bin = 4'(lb);
    bus.en       = e;
    bus.up_dn    = u;
  endtask

  task automatic model_reset();
    m_bin  = 0;
    m_wrap = 0;
  endtask

  // Reference behaviour of one clock edge, from the counting rules.
  task automatic model_edge(input bit l, input int lb, input bit e, input bit u);
    if (l) begin
      m_bin  = lb;
      m_wrap = 0;
    end else if (e) begin
      if (u) begin
        m_wrap = (m_bin == MOD - 1) ? 1 : 0;
        m_bin  = (m_bin + 1) % MOD;
      end else begin
        m_wrap = (m_bin == 0) ? 1 : 0;
        m_bin  = (m_bin + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // One clock: advance the model, sample #1 after the edge, compare.
  task automatic step();
    bit l;
    bit e;
    bit u;
    int lb;
    int prev_gray;
    l         = bus.load;
    e         = bus.en;
    u         = bus.up_dn;
    lb        = int'(bus.load_bin);
    prev_gray = int'(bus.gray);
    @(posedge clk);
    model_edge(l, lb, e, u);
    #1;
    chk("model_bin",  int'(bus.bin),  m_bin);
    chk("model_gray", int'(bus.gray), gray_of(m_bin));
    chk("model_wrap", int'(bus.wrap), m_wrap);
    chk("gray_to_bin", gray_to_bin(int'(bus.gray)), m_bin);
    if (!l && e)
      chk("one_bit_flip", $countones(4'(prev_gray) ^ bus.gray), 1);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 0, 1'b0, 1'b0);
    #2;
    chk("reset_bin",  int'(bus.bin),  0);
    chk("reset_gray", int'(bus.gray), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Full up sweep through wrap-around
    set_in(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("sweep_gray", int'(bus.gray), int'(up_seq[i+1]));
      chk("sweep_wrap", int'(bus.wrap), (i == 15) ? 1 : 0);
    end

    // Stimulus table: loads, down-count wrap, load/en priority, hold
    vecs.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 4'd5,  4'd7,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd4,  4'd6,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  4'd2,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd2,  4'd3,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  4'd1,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  4'd0,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'd8,  1'b1});
    vecs.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 4'd15, 4'd8,  1'b0});
    vecs.push_back('{1'b1, 4'd9,  1'b1, 1'b1, 4'd9,  4'd13, 1'b0});
    vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b1, 4'd3,  4'd2,  1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  4'd6,  1'b0});
    vecs.push_back('{1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 4'd8,  1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'd8,  1'b1});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'd0,  1'b1});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd1,  1'b0});
    foreach (vecs[i]) begin
      set_in(vecs[i].load, int'(vecs[i].load_bin), vecs[i].en, vecs[i].up_dn);
      step();
      chk("vec_bin",  int'(bus.bin),  int'(vecs[i].exp_bin));
      chk("vec_gray", int'(bus.gray), int'(vecs[i].exp_gray));
      chk("vec_wrap", int'(bus.wrap), int'(vecs[i].exp_wrap));
    end

    // Asynchronous reset between edges at bin=0110
    set_in(1'b1, 0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_bin", int'(bus.bin), 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bin",  int'(bus.bin),  0);
    chk("async_rst_gray", int'(bus.gray), 0);
    chk("async_rst_wrap", int'(bus.wrap), 0);
    @(posedge clk);
    #1;
    chk("rst_held_bin", int'(bus.bin), 0);
    #2;
    rst = 1'b0;
    model_reset();
    step();
    chk("resume_bin",  int'(bus.bin),  1);
    chk("resume_gray", int'(bus.gray), 1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7), 1'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
